// File: rtl/image_ram_arbiter.sv
// Arbitrates one single-port image RAM between the VGA display reader and a buffered pixel writer.
// Display reads win, except for a one-cycle forced write after the write buffer has starved too long.
module image_ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 64
) (
  input  logic                          VGA_CLK,
  input  logic                          rst_intern,
  input  logic                          vga_rd_en,
  input  logic [ADDR_W-1:0]             vga_rd_addr,
  output logic [DATA_W-1:0]             vga_rd_data,
  output logic                          vga_rd_valid,
  output logic                          vga_collision,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          ram_we,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   stall_cnt
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int ENTRY_W  = ADDR_W + DATA_W;
  localparam int STARVE_W = $clog2(STARVE_LIM + 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t               state_q;
  logic [STARVE_W-1:0]  starve_q;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]     count_q, count_d;
  logic [15:0]          stall_q, stall_d;
  logic                 rdValid_q;

  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 push;
  logic                 pop;
  logic                 starveCond;
  logic [ENTRY_W-1:0]   headEntry;

  assign fifoFull   = (count_q == LVL_W'(FIFO_DEPTH));
  assign fifoEmpty  = (count_q == '0);
  assign push       = wr_valid && !fifoFull;
  // A FORCE cycle always finds a full buffer; the empty guard keeps pop honest regardless.
  assign pop        = !fifoEmpty && ((state_q == FORCE) || !vga_rd_en);
  assign starveCond = (state_q == NORMAL) && fifoFull && vga_rd_en;
  assign headEntry  = mem_q[rdPtr_q];

  assign wr_ready      = !fifoFull;
  assign ram_we        = pop;
  assign ram_addr      = pop ? headEntry[ENTRY_W-1:DATA_W] : vga_rd_addr;
  assign ram_wdata     = headEntry[DATA_W-1:0];
  assign vga_collision = (state_q == FORCE) && vga_rd_en;
  assign vga_rd_data   = ram_rdata;
  assign vga_rd_valid  = rdValid_q;
  assign fifo_level    = count_q;
  assign stall_cnt     = stall_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    stall_d = stall_q;
    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
    if (wr_valid && fifoFull && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  // Storage is left unreset so it maps onto plain registers or distributed RAM.
  always_ff @(posedge VGA_CLK) begin
    if (push) mem_q[wrPtr_q] <= {wr_addr, wr_data};
  end

  always_ff @(posedge VGA_CLK or posedge rst_intern) begin
    if (rst_intern) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      stall_q   <= '0;
      rdValid_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      stall_q   <= stall_d;
      rdValid_q <= vga_rd_en && !pop;
    end
  end

  // The switch to FORCE is taken as the starve count reaches STARVE_LIM-1, so the
  // forced write lands on the STARVE_LIM-th consecutive blocked cycle.
  always_ff @(posedge VGA_CLK or posedge rst_intern) begin
    if (rst_intern) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (starveCond) begin
            starve_q <= starve_q + STARVE_W'(1);
            if (starve_q == STARVE_W'(STARVE_LIM - 2)) state_q <= FORCE;
          end else begin
            starve_q <= '0;
          end
        end
        FORCE: begin
          state_q  <= NORMAL;
          starve_q <= '0;
        end
        default: begin
          state_q  <= NORMAL;
          starve_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Self-checking bench for image_ram_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model and a behavioural RAM.
module tb_image_ram_arbiter;

  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_LIM = 64;

  logic        VGA_CLK;
  logic        rst_intern;
  logic        vga_rd_en;
  logic [15:0] vga_rd_addr;
  logic [7:0]  vga_rd_data;
  logic        vga_rd_valid;
  logic        vga_collision;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [2:0]  fifo_level;
  logic [15:0] stall_cnt;

  image_ram_arbiter #(
    .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .VGA_CLK(VGA_CLK), .rst_intern(rst_intern),
    .vga_rd_en(vga_rd_en), .vga_rd_addr(vga_rd_addr), .vga_rd_data(vga_rd_data),
    .vga_rd_valid(vga_rd_valid), .vga_collision(vga_collision),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .fifo_level(fifo_level), .stall_cnt(stall_cnt)
  );

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  // Behavioural single-port RAM with one cycle of read latency.
  logic [7:0] ramMem [65536];
  always @(posedge VGA_CLK) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } entry_t;

  entry_t     modelQ[$];
  logic [7:0] modelMem [65536];
  int         starveModel;
  bit         forceOwed;
  int         stallModel;
  bit         expValid;
  logic [7:0] expRdData;
  int         dutFullRun;
  int         collCount;
  bit         prevColl;
  int         compareCount;
  int         failCount;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    starveModel = 0;
    forceOwed   = 1'b0;
    stallModel  = 0;
    expValid    = 1'b0;
    dutFullRun  = 0;
    prevColl    = 1'b0;
  endtask

  // One cycle of the reference: predict this cycle's outputs, compare, then commit the clock edge.
  task automatic modelCycle();
    bit          full;
    bit          eWe;
    bit          eColl;
    logic [15:0] eAddr;
    logic [7:0]  eData;
    bit          nextValid;
    full  = (modelQ.size() == FIFO_DEPTH);
    eWe   = 1'b0;
    eColl = 1'b0;
    eAddr = vga_rd_addr;
    eData = 8'h00;
    if (forceOwed) begin
      eWe   = 1'b1;
      eAddr = modelQ[0].a;
      eData = modelQ[0].d;
      eColl = vga_rd_en;
    end else if (!vga_rd_en && modelQ.size() > 0) begin
      eWe   = 1'b1;
      eAddr = modelQ[0].a;
      eData = modelQ[0].d;
    end

    checkOutput("wr_ready", 32'(wr_ready), 32'(!full));
    checkOutput("fifo_level", 32'(fifo_level), 32'(modelQ.size()));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(stallModel));
    checkOutput("rd_valid", 32'(vga_rd_valid), 32'(expValid));
    if (expValid) checkOutput("rd_data", 32'(vga_rd_data), 32'(expRdData));
    checkOutput("ram_we", 32'(ram_we), 32'(eWe));
    checkOutput("ram_addr", 32'(ram_addr), 32'(eAddr));
    if (eWe) checkOutput("ram_wdata", 32'(ram_wdata), 32'(eData));
    checkOutput("collision", 32'(vga_collision), 32'(eColl));

    if (vga_rd_en && !wr_ready) dutFullRun++;
    else dutFullRun = 0;
    if (vga_collision === 1'b1) begin
      collCount++;
      checkOutput("starve_cycle", 32'(dutFullRun), 32'(STARVE_LIM));
    end
    if (prevColl) checkOutput("valid_after_collision", 32'(vga_rd_valid), 32'(0));
    prevColl = (vga_collision === 1'b1);

    nextValid = vga_rd_en && !eWe;
    if (nextValid) expRdData = modelMem[vga_rd_addr];
    if (eWe) begin
      modelMem[eAddr] = eData;
      void'(modelQ.pop_front());
    end
    if (forceOwed) begin
      forceOwed   = 1'b0;
      starveModel = 0;
    end else if (vga_rd_en && full) begin
      starveModel++;
      if (starveModel == STARVE_LIM - 1) forceOwed = 1'b1;
    end else begin
      starveModel = 0;
    end
    if (wr_valid && !full) modelQ.push_back('{a: wr_addr, d: wr_data});
    if (wr_valid && full && stallModel < 65535) stallModel++;
    expValid = nextValid;
  endtask

  task automatic applyStimulus(input bit rdEn, input logic [15:0] rdAddr, input bit wrV,
                               input logic [15:0] wA, input logic [7:0] wD);
    @(negedge VGA_CLK);
    vga_rd_en   = rdEn;
    vga_rd_addr = rdAddr;
    wr_valid    = wrV;
    wr_addr     = wA;
    wr_data     = wD;
    #1;
    modelCycle();
  endtask

  task automatic doAsyncReset();
    @(negedge VGA_CLK);
    vga_rd_en = 1'b1;
    wr_valid  = 1'b0;
    #1;
    checkOutput("level_before_reset", 32'(fifo_level), 32'(modelQ.size()));
    #1;
    rst_intern = 1'b1;
    #1;
    checkOutput("rst_fifo_level", 32'(fifo_level), 32'(0));
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'(1));
    checkOutput("rst_ram_we", 32'(ram_we), 32'(0));
    checkOutput("rst_collision", 32'(vga_collision), 32'(0));
    resetModel();
    vga_rd_en = 1'b0;
    @(negedge VGA_CLK);
    checkOutput("rst_hold_ram_we", 32'(ram_we), 32'(0));
    rst_intern = 1'b0;
  endtask

  initial begin
    int pct;
    for (int i = 0; i < 65536; i++) begin
      ramMem[i]   = 8'(i * 7 + 3);
      modelMem[i] = 8'(i * 7 + 3);
    end
    compareCount = 0;
    failCount    = 0;
    collCount    = 0;
    expRdData    = 8'h00;
    rst_intern   = 1'b1;
    vga_rd_en    = 1'b0;
    vga_rd_addr  = 16'h0000;
    wr_valid     = 1'b0;
    wr_addr      = 16'h0000;
    wr_data      = 8'h00;
    resetModel();

    repeat (2) @(negedge VGA_CLK);
    #1;
    checkOutput("init_fifo_level", 32'(fifo_level), 32'(0));
    checkOutput("init_wr_ready", 32'(wr_ready), 32'(1));
    checkOutput("init_ram_we", 32'(ram_we), 32'(0));
    checkOutput("init_collision", 32'(vga_collision), 32'(0));
    checkOutput("init_rd_valid", 32'(vga_rd_valid), 32'(0));
    checkOutput("init_stall", 32'(stall_cnt), 32'(0));
    @(negedge VGA_CLK);
    rst_intern = 1'b0;

    // Idle write goes straight through on the following cycle.
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0102, 8'hAB);
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("idle_we", 32'(ram_we), 32'(1));
    checkOutput("idle_addr", 32'(ram_addr), 32'h0102);
    checkOutput("idle_wdata", 32'(ram_wdata), 32'hAB);
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("idle_level", 32'(fifo_level), 32'(0));

    // Read latency: write 0x5A, read it back one cycle later.
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h3344, 8'h5A);
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b1, 16'h3344, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("latency_valid", 32'(vga_rd_valid), 32'(1));
    checkOutput("latency_data", 32'(vga_rd_data), 32'h5A);

    // Reads hold off three buffered writes, which then drain in order.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 16'($urandom), (i < 3), 16'(16'h1000 + i), 8'(8'h10 + i));
    checkOutput("read_priority_level", 32'(fifo_level), 32'(3));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
      checkOutput("drain_order", 32'(ram_addr), 32'(16'h1000 + i));
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);

    // Full buffer under continuous reads, through one starvation-forced write.
    collCount = 0;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b1, 16'($urandom), 1'b1, 16'($urandom), 8'($urandom));
      if (i == 4) checkOutput("full_wr_ready", 32'(wr_ready), 32'(0));
      if (i == 7) checkOutput("stall_three", 32'(stall_cnt), 32'(3));
    end
    checkOutput("collision_count", 32'(collCount), 32'(1));

    // Drain, partially refill, then reset asynchronously mid-fill.
    repeat (6) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'($urandom), 1'b1, 16'(16'h2000 + i), 8'(8'h20 + i));
    doAsyncReset();
    repeat (4) applyStimulus(1'b0, 16'($urandom), 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0042, 8'h77);
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("post_reset_write", 32'(ram_addr), 32'h0042);

    // Random traffic over a small address window so reads revisit written pixels.
    for (int phase = 0; phase < 4; phase++) begin
      pct = (phase == 0) ? 30 : (phase == 1) ? 70 : (phase == 2) ? 97 : 50;
      for (int i = 0; i < 100; i++)
        applyStimulus(($urandom_range(0, 99) < pct), 16'($urandom_range(0, 63)),
                      ($urandom_range(0, 99) < 60), 16'($urandom_range(0, 63)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
